// File: rtl/lorenz_integrator_param.sv
// Fixed-point forward-Euler Lorenz solver with one time-shared multiplier and a ready/valid output.
// Define LORENZ_SATURATE_EN to clamp on overflow and raise the sticky ovf flag; otherwise values wrap.
module lorenz_integrator_param #(
    parameter int unsigned WIDTH    = 27,
    parameter int unsigned FRAC     = 20,
    parameter int unsigned DT_SHIFT = 8,
    parameter int unsigned GUARD    = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic [WIDTH-1:0] init_x,
    input  logic [WIDTH-1:0] init_y,
    input  logic [WIDTH-1:0] init_z,
    input  logic [WIDTH-1:0] sigma,
    input  logic [WIDTH-1:0] beta,
    input  logic [WIDTH-1:0] rho,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] step_count,
    output logic             ovf
);

    localparam int unsigned IW = WIDTH + GUARD;
    localparam int unsigned PW = 2 * IW;

`ifdef LORENZ_SATURATE_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    localparam logic signed [IW-1:0]    IwMax = {1'b0, {(IW - 1){1'b1}}};
    localparam logic signed [IW-1:0]    IwMin = {1'b1, {(IW - 1){1'b0}}};
    localparam logic signed [WIDTH-1:0] WMax  = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic signed [WIDTH-1:0] WMin  = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StMul0,
        StMul1,
        StMul2,
        StMul3,
        StUpdate,
        StValid
    } state_e;

    state_e state_q, state_d;

    logic signed [WIDTH-1:0] x_q, y_q, z_q, sigma_q, beta_q, rho_q;
    logic signed [IW-1:0]    p0_q, p1_q, p2_q, p3_q;
    logic [CNT_W-1:0]        cnt_q;

    logic signed [IW-1:0] x_e, y_e, z_e, sigma_e, beta_e, rho_e;

    assign x_e     = {{GUARD{x_q[WIDTH-1]}}, x_q};
    assign y_e     = {{GUARD{y_q[WIDTH-1]}}, y_q};
    assign z_e     = {{GUARD{z_q[WIDTH-1]}}, z_q};
    assign sigma_e = {{GUARD{sigma_q[WIDTH-1]}}, sigma_q};
    assign beta_e  = {{GUARD{beta_q[WIDTH-1]}}, beta_q};
    assign rho_e   = {{GUARD{rho_q[WIDTH-1]}}, rho_q};

    // Shared multiplier: operand pair selected by the current MUL state
    logic signed [IW-1:0] mul_a, mul_b, prod_red;
    logic signed [PW-1:0] mul_full, mul_shr;
    logic                 mul_en, prod_clip;

    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        mul_en = 1'b1;
        case (state_q)
            StMul0: begin mul_a = sigma_e; mul_b = y_e - x_e;   end
            StMul1: begin mul_a = x_e;     mul_b = rho_e - z_e; end
            StMul2: begin mul_a = x_e;     mul_b = y_e;         end
            StMul3: begin mul_a = beta_e;  mul_b = z_e;         end
            default: mul_en = 1'b0;
        endcase
    end

    assign mul_full  = mul_a * mul_b;
    assign mul_shr   = mul_full >>> FRAC;
    assign prod_clip = !((&mul_shr[PW-1:IW-1]) || !(|mul_shr[PW-1:IW-1]));
    assign prod_red  = (SatEn && prod_clip) ? (mul_shr[PW-1] ? IwMin : IwMax)
                                            : mul_shr[IW-1:0];

    // Derivatives and Euler update; sums carry one extra bit to detect overflow
    logic signed [IW:0]      dy_w, dz_w;
    logic                    dy_clip, dz_clip;
    logic signed [IW-1:0]    dy, dz;
    logic signed [IW-1:0]    st_e   [3];
    logic signed [IW-1:0]    dd     [3];
    logic signed [IW-1:0]    incr   [3];
    logic signed [IW:0]      sum    [3];
    logic signed [WIDTH-1:0] new_st [3];
    logic [2:0]              upd_clip;

    assign dy_w    = {p1_q[IW-1], p1_q} - {y_e[IW-1], y_e};
    assign dz_w    = {p2_q[IW-1], p2_q} - {p3_q[IW-1], p3_q};
    assign dy_clip = dy_w[IW] != dy_w[IW-1];
    assign dz_clip = dz_w[IW] != dz_w[IW-1];
    assign dy      = (SatEn && dy_clip) ? (dy_w[IW] ? IwMin : IwMax) : dy_w[IW-1:0];
    assign dz      = (SatEn && dz_clip) ? (dz_w[IW] ? IwMin : IwMax) : dz_w[IW-1:0];

    always_comb begin
        st_e[0] = x_e;
        st_e[1] = y_e;
        st_e[2] = z_e;
        dd[0]   = p0_q;
        dd[1]   = dy;
        dd[2]   = dz;
        for (int i = 0; i < 3; i++) begin
            incr[i]     = dd[i] >>> DT_SHIFT;
            sum[i]      = {st_e[i][IW-1], st_e[i]} + {incr[i][IW-1], incr[i]};
            upd_clip[i] = !((&sum[i][IW:WIDTH-1]) || !(|sum[i][IW:WIDTH-1]));
            if (SatEn && upd_clip[i]) begin
                new_st[i] = sum[i][IW] ? WMin : WMax;
            end else begin
                new_st[i] = sum[i][WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StMul0;
            StMul0:   state_d = StMul1;
            StMul1:   state_d = StMul2;
            StMul2:   state_d = StMul3;
            StMul3:   state_d = StUpdate;
            StUpdate: state_d = StValid;
            StValid:  if (out_ready) state_d = run ? StMul0 : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        out_valid = (state_q == StValid);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            sigma_q <= '0;
            beta_q  <= '0;
            rho_q   <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        x_q     <= init_x;
                        y_q     <= init_y;
                        z_q     <= init_z;
                        sigma_q <= sigma;
                        beta_q  <= beta;
                        rho_q   <= rho;
                    end
                end
                StMul0: p0_q <= prod_red;
                StMul1: p1_q <= prod_red;
                StMul2: p2_q <= prod_red;
                StMul3: p3_q <= prod_red;
                StUpdate: begin
                    x_q <= new_st[0];
                    y_q <= new_st[1];
                    z_q <= new_st[2];
                end
                StValid: if (out_ready) cnt_q <= cnt_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef LORENZ_SATURATE_EN
    logic ovf_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if ((mul_en && prod_clip) ||
                     ((state_q == StUpdate) && (dy_clip || dz_clip || (|upd_clip)))) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign z_out      = z_q;
    assign step_count = cnt_q;

endmodule
